// File: rtl/reset_ctrl.sv
// Reset sequencer: synchronises and debounces the reset switch, synchronises the
// clock-manager lock flag, and holds chip_reset until lock has been stable long enough.
module reset_ctrl #(
  parameter int unsigned DEBOUNCE_CYC  = 65536,
  parameter int unsigned HOLD_CYC      = 1024,
  parameter bit          SW_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_sw,
  input  logic       locked,
  output logic       chip_reset,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;

  typedef enum logic [1:0] {
    S_ASSERT    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic              sw_pressed;
  logic              sw_meta, sw_sync, sw_db;
  logic              lock_meta, lock_sync;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  state_t            state, state_nxt;
  logic [1:0]        cause_nxt;
  logic [7:0]        count_nxt, count_inc;

  assign sw_pressed = SW_ACTIVE_LOW ? ~reset_sw : reset_sw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta   <= 1'b0;
      sw_sync   <= 1'b0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sw_meta   <= sw_pressed;
      sw_sync   <= sw_meta;
      lock_meta <= locked;
      lock_sync <= lock_meta;
    end
  end

  // Counter only runs while the synced and debounced values disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      sw_db  <= 1'b0;
    end else if (sw_sync == sw_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      sw_db  <= sw_sync;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign count_inc = (rst_count == '1) ? rst_count : rst_count + 8'd1;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    cause_nxt = rst_cause;
    count_nxt = rst_count;
    case (state)
      S_ASSERT: begin
        if (!sw_db) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_sync) begin
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end
      end
      S_HOLD: begin
        if (sw_db)                      state_nxt = S_ASSERT;
        else if (!lock_sync)            state_nxt = S_WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
        else                            hold_nxt  = hold_cnt + HOLD_W'(1);
      end
      S_RUN: begin
        // Switch takes priority when it coincides with lock loss.
        if (sw_db) begin
          state_nxt = S_ASSERT;
          cause_nxt = CAUSE_SW;
          count_nxt = count_inc;
        end else if (!lock_sync) begin
          state_nxt = S_WAIT_LOCK;
          cause_nxt = CAUSE_LOCK;
          count_nxt = count_inc;
        end
      end
      default: state_nxt = S_ASSERT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_ASSERT;
      hold_cnt   <= '0;
      chip_reset <= 1'b1;
      rst_cause  <= CAUSE_POR;
      rst_count  <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      chip_reset <= (state_nxt != S_RUN);
      rst_cause  <= cause_nxt;
      rst_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl with DEBOUNCE_CYC=4, HOLD_CYC=8, active-low switch: per-cycle
// vector table for POR/switch/glitch/lock-loss, then hand sequences for the corner cases.
module tb_reset_ctrl;

  logic       clk;
  logic       reset;
  logic       reset_sw;
  logic       locked;
  logic       chip_reset;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int unsigned total;
  int unsigned passed;

  typedef struct {
    logic       rst;
    logic       sw;
    logic       lk;
    logic       cr;
    logic [1:0] cause;
    logic [7:0] count;
  } vec_t;

  vec_t vecs[$];

  reset_ctrl #(
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (8),
    .SW_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reset_sw  (reset_sw),
    .locked    (locked),
    .chip_reset(chip_reset),
    .rst_cause (rst_cause),
    .rst_count (rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input int unsigned n, input logic r, input logic s, input logic l,
                              input logic cr, input logic [1:0] cause, input logic [7:0] count);
    vec_t v;
    v.rst = r; v.sw = s; v.lk = l; v.cr = cr; v.cause = cause; v.count = count;
    for (int unsigned k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string name, input logic cr, input logic [1:0] cause,
                         input logic [7:0] count);
    chk({name, ".chip_reset"}, {7'd0, chip_reset}, {7'd0, cr});
    chk({name, ".rst_cause"},  {6'd0, rst_cause},  {6'd0, cause});
    chk({name, ".rst_count"},  rst_count,          count);
  endtask

  // Drive inputs away from the edge, then advance one edge and settle.
  task automatic step(input logic r, input logic s, input logic l);
    reset = r; reset_sw = s; locked = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned model;
    total  = 0;
    passed = 0;
    reset = 1'b1; reset_sw = 1'b1; locked = 1'b1;

    // POR: falls on edge 11 after release
    add(3,  1, 1, 1, 1, 2'd0, 8'd0);
    add(10, 0, 1, 1, 1, 2'd0, 8'd0);
    add(5,  0, 1, 1, 0, 2'd0, 8'd0);
    // switch pressed 20 cycles: rises on edge 7
    add(6,  0, 0, 1, 0, 2'd0, 8'd0);
    add(14, 0, 0, 1, 1, 2'd1, 8'd1);
    // switch released: falls on edge 16
    add(15, 0, 1, 1, 1, 2'd1, 8'd1);
    add(4,  0, 1, 1, 0, 2'd1, 8'd1);
    // glitches of 1, 2, 3 cycles are ignored
    add(1,  0, 0, 1, 0, 2'd1, 8'd1);
    add(10, 0, 1, 1, 0, 2'd1, 8'd1);
    add(2,  0, 0, 1, 0, 2'd1, 8'd1);
    add(10, 0, 1, 1, 0, 2'd1, 8'd1);
    add(3,  0, 0, 1, 0, 2'd1, 8'd1);
    add(10, 0, 1, 1, 0, 2'd1, 8'd1);
    // lock lost 5 cycles: rises on edge 3; back: falls 11 edges after return
    add(2,  0, 1, 0, 0, 2'd1, 8'd1);
    add(3,  0, 1, 0, 1, 2'd2, 8'd2);
    add(10, 0, 1, 1, 1, 2'd2, 8'd2);
    add(3,  0, 1, 1, 0, 2'd2, 8'd2);

    #1;
    chk_out("por_async", 1'b1, 2'd0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].sw, vecs[i].lk);
      chk_out($sformatf("vec%0d", i), vecs[i].cr, vecs[i].cause, vecs[i].count);
    end

    // A: debounced switch and lock loss reach the FSM on the same edge
    repeat (4) step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    chk_out("simul_pre", 1'b0, 2'd2, 8'd2);
    step(0, 0, 0);
    chk_out("simul_hit", 1'b1, 2'd1, 8'd3);
    repeat (3) step(0, 0, 0);
    chk_out("simul_hold", 1'b1, 2'd1, 8'd3);
    repeat (15) step(0, 1, 1);
    chk_out("simul_rel15", 1'b1, 2'd1, 8'd3);
    step(0, 1, 1);
    chk_out("simul_rel16", 1'b0, 2'd1, 8'd3);

    // B: one-cycle lock drop mid-HOLD restarts the full window
    repeat (5) step(0, 1, 0);
    chk_out("abort_loss", 1'b1, 2'd2, 8'd4);
    repeat (5) step(0, 1, 1);
    step(0, 1, 0);
    repeat (10) step(0, 1, 1);
    chk_out("abort_e16", 1'b1, 2'd2, 8'd4);
    step(0, 1, 1);
    chk_out("abort_e17", 1'b0, 2'd2, 8'd4);

    // Saturation over 260 lock-loss events
    model = 4;
    for (int e = 0; e < 260; e++) begin
      repeat (3) step(0, 1, 0);
      repeat (12) step(0, 1, 1);
      if (model < 255) model++;
      chk($sformatf("sat_count%0d", e), rst_count, model[7:0]);
    end
    chk_out("sat_run", 1'b0, 2'd2, 8'd255);

    // Asynchronous reset while in HOLD
    repeat (3) step(0, 1, 0);
    repeat (5) step(0, 1, 1);
    chk_out("mid_hold", 1'b1, 2'd2, 8'd255);
    reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b1, 2'd0, 8'd0);
    repeat (2) step(1, 1, 1);
    repeat (10) step(0, 1, 1);
    chk_out("repor_e10", 1'b1, 2'd0, 8'd0);
    step(0, 1, 1);
    chk_out("repor_e11", 1'b0, 2'd0, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
